multdiv_sequencer: RTL and testbench
====================================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameters SHALL be: STATUS_REG, 30, register index written on exception; MUL_EXC_CODE, 4, status value for mul overflow; DIV_EXC_CODE, 5, status value for div by zero; TIMEOUT_EXC_CODE, 6, status value on watchdog expiry; TIMEOUT, 48, max BUSY cycles before abort.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  async active-high reset
- issue_mul  in  1  pipeline requests multiply
- issue_div  in  1  pipeline requests divide
- op_a  in  32  operand A
- op_b  in  32  operand B
- rd_in  in  5  destination register
- flush  in  1  cancel in-flight op
- md_result  in  32  multdiv result
- md_exception  in  1  multdiv exception
- md_rdy  in  1  multdiv ready
- md_start_mul  out  1  one-cycle multiply start pulse
- md_start_div  out  1  one-cycle divide start pulse
- md_op_a  out  32  held operand A
- md_op_b  out  32  held operand B
- stall  out  1  freeze pipeline
- wb_valid  out  1  writeback pending
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- wb_ack  in  1  regfile accepted writeback

Function
REQ-004 The FSM SHALL have states IDLE, START, BUSY, WB.
REQ-005 IDLE: on issue_mul or issue_div, the block SHALL capture op_a, op_b, rd_in and op type, and go to START next cycle; issue_mul SHALL win when both are high.
REQ-006 The block SHALL ignore issue_* outside IDLE, with no state change.
REQ-007 START: exactly one of md_start_mul/md_start_div SHALL be high for exactly one cycle, then go to BUSY with the cycle counter cleared.
REQ-008 md_op_a/md_op_b SHALL hold the captured operands constant from START through WB.
REQ-009 BUSY: the counter SHALL increment each cycle; md_rdy SHALL be ignored in the first BUSY cycle (stale ready from a prior op).
REQ-010 BUSY, md_rdy high with md_exception low: the block SHALL set wb_rd to the captured rd and wb_data to md_result, then go to WB.
REQ-011 BUSY, md_rdy high with md_exception high: the block SHALL set wb_rd to STATUS_REG and wb_data to MUL_EXC_CODE or DIV_EXC_CODE per op type, then go to WB.
REQ-012 BUSY, counter reaching TIMEOUT without md_rdy: the block SHALL set wb_rd to STATUS_REG and wb_data to TIMEOUT_EXC_CODE, then go to WB.
REQ-013 WB: wb_valid SHALL be high, and wb_rd/wb_data SHALL be stable until wb_ack; on wb_ack it SHALL go to IDLE next cycle.
REQ-014 stall SHALL be high exactly when state is START, BUSY or WB (registered decode, no combinational path from issue_*).
REQ-015 flush in START or BUSY SHALL return to IDLE next cycle with no writeback; a late md_rdy is discarded.
REQ-016 flush in WB SHALL be ignored; the writeback is committed.
REQ-017 flush and md_rdy in the same BUSY cycle: flush SHALL win.
REQ-018 wb_ack outside WB SHALL have no effect.
REQ-019 Latency SHALL be: issue accepted cycle N; start pulse cycle N+1; wb_valid the cycle after the qualifying md_rdy.

Reset
REQ-020 Reset SHALL force IDLE, counter 0, and all outputs 0 immediately, including mid-operation and during WB.
REQ-021 After reset deasserts, the first issue_* SHALL be accepted normally.

Verification
REQ-022 The bench SHALL cover these scenarios:
- issue_mul, op_a=7, op_b=6, rd_in=3; md_rdy after 33 cycles, md_result=42 -> single md_start_mul pulse; stall high; wb_valid with wb_rd=3, wb_data=42; IDLE after wb_ack.
- issue_div, op_b=0; md_rdy with md_exception=1 -> wb_rd=30, wb_data=5.
- md_rdy held high through START and first BUSY cycle, then low; real md_rdy at cycle 10 -> result captured at cycle 10 only.
- issue_mul, md_rdy never asserted -> after 48 BUSY cycles wb_rd=30, wb_data=6.
- flush in BUSY cycle 5 -> IDLE, wb_valid never high, stall low next cycle; flush in WB -> writeback still completes.
- reset asserted in BUSY and in WB -> outputs 0 immediately; new issue_div afterwards completes normally.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - sequences one multiply/divide op from issue to register writeback
// Holds the operands, starts the unit, waits for ready or watchdog expiry, then presents one writeback.
module multdiv_sequencer #(
  parameter int STATUS_REG       = 30,
  parameter int MUL_EXC_CODE     = 4,
  parameter int DIV_EXC_CODE     = 5,
  parameter int TIMEOUT_EXC_CODE = 6,
  parameter int TIMEOUT          = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mul,
  input  logic        issue_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_rdy,
  output logic        md_start_mul,
  output logic        md_start_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]  STATUS_RD = 5'(STATUS_REG);
  localparam logic [31:0] MUL_EXC   = 32'(MUL_EXC_CODE);
  localparam logic [31:0] DIV_EXC   = 32'(DIV_EXC_CODE);
  localparam logic [31:0] TMO_EXC   = 32'(TIMEOUT_EXC_CODE);

  typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

  state_t          state_q, state_d;
  logic            is_mul_q, is_mul_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            md_start_mul_q, md_start_mul_d;
  logic            md_start_div_q, md_start_div_d;
  logic [31:0]     md_op_a_q, md_op_a_d;
  logic [31:0]     md_op_b_q, md_op_b_d;
  logic            stall_q, stall_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;

  always_comb begin
    state_d        = state_q;
    is_mul_d       = is_mul_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    md_start_mul_d = 1'b0;
    md_start_div_d = 1'b0;
    md_op_a_d      = md_op_a_q;
    md_op_b_d      = md_op_b_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;

    case (state_q)
      IDLE: begin
        if (issue_mul || issue_div) begin
          state_d        = START;
          is_mul_d       = issue_mul;
          rd_d           = rd_in;
          md_op_a_d      = op_a;
          md_op_b_d      = op_b;
          md_start_mul_d = issue_mul;
          md_start_div_d = !issue_mul;
          cnt_d          = '0;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = flush ? IDLE : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // cnt_q == 0 is the first BUSY cycle, where ready may be left over from the previous op
        if (flush) begin
          state_d = IDLE;
        end else if (md_rdy && cnt_q != '0) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          if (md_exception) begin
            wb_rd_d   = STATUS_RD;
            wb_data_d = is_mul_q ? MUL_EXC : DIV_EXC;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = md_result;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_rd_d    = STATUS_RD;
          wb_data_d  = TMO_EXC;
        end
      end
      WB: begin
        if (wb_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
          wb_rd_d    = '0;
          wb_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      is_mul_q       <= 1'b0;
      rd_q           <= '0;
      cnt_q          <= '0;
      md_start_mul_q <= 1'b0;
      md_start_div_q <= 1'b0;
      md_op_a_q      <= '0;
      md_op_b_q      <= '0;
      stall_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      is_mul_q       <= is_mul_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      md_start_mul_q <= md_start_mul_d;
      md_start_div_q <= md_start_div_d;
      md_op_a_q      <= md_op_a_d;
      md_op_b_q      <= md_op_b_d;
      stall_q        <= stall_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign md_start_mul = md_start_mul_q;
  assign md_start_div = md_start_div_q;
  assign md_op_a      = md_op_a_q;
  assign md_op_b      = md_op_b_q;
  assign stall        = stall_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_mul, issue_div, flush, md_exception, md_rdy, wb_ack;
  logic [31:0] op_a, op_b, md_result;
  logic [4:0]  rd_in;
  logic        md_start_mul, md_start_div, stall, wb_valid;
  logic [31:0] md_op_a, md_op_b, wb_data;
  logic [4:0]  wb_rd;

  int tests  = 0;
  int failed = 0;
  int bad;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .issue_mul(issue_mul), .issue_div(issue_div),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush), .md_result(md_result),
    .md_exception(md_exception), .md_rdy(md_rdy), .md_start_mul(md_start_mul),
    .md_start_div(md_start_div), .md_op_a(md_op_a), .md_op_b(md_op_b), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic mul, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    issue_mul = mul; issue_div = div; op_a = a; op_b = b; rd_in = rd;
    step();
    issue_mul = 0; issue_div = 0; op_a = 0; op_b = 0; rd_in = 0;
  endtask

  task automatic ack();
    wb_ack = 1;
    step();
    wb_ack = 0;
  endtask

  initial begin
    reset = 1; issue_mul = 0; issue_div = 0; flush = 0; md_exception = 0;
    md_rdy = 0; wb_ack = 0; op_a = 0; op_b = 0; md_result = 0; rd_in = 0;
    step(); step();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_start", 32'({md_start_mul, md_start_div}), 0);
    chk("rst_wb_data", wb_data, 0);
    reset = 0;
    step();

    // multiply 7*6 -> r3, ready in BUSY cycle 33; stray issue and ack in BUSY ignored
    issue(1, 0, 7, 6, 3);
    chk("s1_start_mul", 32'(md_start_mul), 1);
    chk("s1_start_div", 32'(md_start_div), 0);
    chk("s1_stall", 32'(stall), 1);
    chk("s1_op_a", md_op_a, 7);
    chk("s1_op_b", md_op_b, 6);
    step();
    chk("s1_pulse_one_cycle", 32'(md_start_mul), 0);
    issue_div = 1; wb_ack = 1;
    step();
    issue_div = 0; wb_ack = 0;
    bad = 0;
    for (int i = 1; i < 33; i++) begin
      bad += int'(md_start_mul) + int'(md_start_div) + int'(wb_valid) + int'(!stall);
      step();
    end
    chk("s1_busy_quiet", 32'(bad), 0);
    chk("s1_op_a_held", md_op_a, 7);
    md_rdy = 1; md_result = 42;
    step();
    md_rdy = 0; md_result = 0;
    chk("s1_wb_valid", 32'(wb_valid), 1);
    chk("s1_wb_rd", 32'(wb_rd), 3);
    chk("s1_wb_data", wb_data, 42);
    step();
    chk("s1_wb_hold_valid", 32'(wb_valid), 1);
    chk("s1_wb_hold_data", wb_data, 42);
    chk("s1_op_b_held_wb", md_op_b, 6);
    ack();
    chk("s1_idle_valid", 32'(wb_valid), 0);
    chk("s1_idle_stall", 32'(stall), 0);

    // divide by zero with exception -> status reg 30, code 5
    issue(0, 1, 100, 0, 9);
    chk("s2_start_div", 32'(md_start_div), 1);
    chk("s2_start_mul", 32'(md_start_mul), 0);
    step(); step();
    md_rdy = 1; md_exception = 1; md_result = 32'hdead;
    step();
    md_rdy = 0; md_exception = 0; md_result = 0;
    chk("s2_wb_rd", 32'(wb_rd), 30);
    chk("s2_wb_data", wb_data, 5);
    ack();

    // both issues high: multiply wins, exception gives code 4
    issue(1, 1, 1, 1, 2);
    chk("s2b_start_mul", 32'(md_start_mul), 1);
    chk("s2b_start_div", 32'(md_start_div), 0);
    step(); step();
    md_rdy = 1; md_exception = 1;
    step();
    md_rdy = 0; md_exception = 0;
    chk("s2b_wb_data", wb_data, 4);
    ack();

    // stale ready through START and first BUSY cycle, real ready at BUSY cycle 10
    md_rdy = 1; md_result = 99;
    issue(1, 0, 3, 5, 7);
    step();
    step();
    md_rdy = 0;
    chk("s3_stale_ignored", 32'(wb_valid), 0);
    for (int i = 1; i < 10; i++) step();
    chk("s3_before_real", 32'(wb_valid), 0);
    md_rdy = 1; md_result = 15;
    step();
    md_rdy = 0; md_result = 0;
    chk("s3_wb_data", wb_data, 15);
    chk("s3_wb_rd", 32'(wb_rd), 7);
    ack();

    // watchdog: 48 BUSY cycles without ready
    issue(1, 0, 8, 8, 4);
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      bad += int'(wb_valid);
    end
    chk("s4_no_early_wb", 32'(bad), 0);
    step();
    chk("s4_wb_valid", 32'(wb_valid), 1);
    chk("s4_wb_rd", 32'(wb_rd), 30);
    chk("s4_wb_data", wb_data, 6);
    ack();

    // flush with ready in BUSY cycle 5: flush wins, late ready discarded
    issue(0, 1, 9, 3, 6);
    for (int i = 0; i < 6; i++) step();
    flush = 1; md_rdy = 1; md_result = 77;
    step();
    flush = 0;
    chk("s5_flush_stall", 32'(stall), 0);
    chk("s5_flush_wb", 32'(wb_valid), 0);
    step();
    md_rdy = 0; md_result = 0;
    chk("s5_late_rdy", 32'(wb_valid), 0);

    // flush in START
    issue(1, 0, 2, 2, 1);
    flush = 1;
    step();
    flush = 0;
    chk("s5_flush_start", 32'(stall), 0);

    // flush in WB ignored
    issue(1, 0, 4, 4, 12);
    step(); step();
    md_rdy = 1; md_result = 32'h1234;
    step();
    md_rdy = 0; md_result = 0;
    flush = 1;
    step();
    flush = 0;
    chk("s5_wb_flush_valid", 32'(wb_valid), 1);
    chk("s5_wb_flush_data", wb_data, 32'h1234);
    chk("s5_wb_flush_rd", 32'(wb_rd), 12);
    ack();
    chk("s5_wb_done", 32'(wb_valid), 0);

    // reset in BUSY
    issue(1, 0, 1, 2, 3);
    step(); step();
    #2 reset = 1;
    #1;
    chk("s6_busy_rst_stall", 32'(stall), 0);
    chk("s6_busy_rst_op_a", md_op_a, 0);
    step();
    reset = 0;

    // reset in WB
    issue(1, 0, 1, 2, 3);
    step(); step();
    md_rdy = 1; md_result = 2;
    step();
    md_rdy = 0; md_result = 0;
    chk("s6_in_wb", 32'(wb_valid), 1);
    #2 reset = 1;
    #1;
    chk("s6_wb_rst_valid", 32'(wb_valid), 0);
    chk("s6_wb_rst_rd", 32'(wb_rd), 0);
    chk("s6_wb_rst_data", wb_data, 0);
    chk("s6_wb_rst_stall", 32'(stall), 0);
    step();
    reset = 0;

    // first issue after reset completes normally
    issue(0, 1, 20, 4, 5);
    chk("s6_post_start_div", 32'(md_start_div), 1);
    step(); step();
    md_rdy = 1; md_result = 5;
    step();
    md_rdy = 0; md_result = 0;
    chk("s6_post_wb_rd", 32'(wb_rd), 5);
    chk("s6_post_wb_data", wb_data, 5);
    ack();
    chk("s6_post_idle", 32'(stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
